branch_predict_resolve: RTL and testbench
=========================================

// Module: branch_predict_resolve
// PURPOSE
//  Next-generation branch unit: resolves conditional branches, JAL and JALR in EX, and owns a direct-mapped
//  BHT (2-bit counters) plus BTB, which give fetch a same-cycle prediction. It raises a registered redirect on
//  mispredict and keeps wrap-around branch/mispredict performance counters. Sits between IF (lookup) and EX
//  (resolve/update) of the 5-stage core.
// PARAMETERS
//  XLEN      32  data/address width
//  IDX_BITS   6  BHT/BTB index width (2**IDX_BITS entries), index = pc[IDX_BITS+1:2]
//  TAG_BITS   8  BTB tag width, tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
//  CNT_W     32  performance counter width
// PORTS
//  clk              in   1         clock, all state on rising edge
//  rst              in   1         synchronous, active-high reset
//  if_pc            in   XLEN      fetch PC for lookup
//  if_pred_taken    out  1         prediction: take target (combinational from array state)
//  if_pred_target   out  XLEN      predicted target (valid when if_pred_taken)
//  ex_valid         in   1         EX holds a real instruction this cycle
//  ex_pc, ex_imm    in   XLEN      PC and sign-extended immediate of EX instr
//  ex_rs1, ex_rs2   in   XLEN      forwarded operands
//  ex_funct3        in   3         branch condition select
//  ex_branch/ex_jump/ex_alu_src in 1 each  cond branch / JAL(R) / JALR selects rs1 base
//  ex_pred_taken    in   1         prediction carried down pipe with the instr
//  ex_pred_target   in   XLEN      predicted target carried down pipe
//  redirect_valid   out  1         registered: flush younger instrs and refetch
//  redirect_pc      out  XLEN      registered refetch address
//  br_count         out  CNT_W     resolved branches+jumps
//  mispred_count    out  CNT_W     resolved mispredicts
// BEHAVIOUR
//  Reset: redirect_valid=0, redirect_pc=0, counters=0, all BTB valid=0, all BHT counters=2'b01 (weak NT).
//  Resolve (combinational in EX, only if ex_valid & (ex_branch|ex_jump)):
//   - target = (ex_alu_src ? ex_rs1 : ex_pc) + ex_imm, modulo 2**XLEN; JALR (jump&alu_src) clears bit 0.
//   - taken = ex_jump | (ex_branch & cond); cond by funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed,
//     110 LTU, 111 GEU; 010/011 never taken.
//   - mispredict = (taken != ex_pred_taken) | (taken & ex_pred_target != target).
//  Redirect: 1-cycle latency. Next cycle redirect_valid=mispredict, redirect_pc = taken ? target : ex_pc+4.
//   redirect_valid is a single-cycle pulse; never asserted for ex_valid=0 or non-control instrs.
//  Update (same edge as redirect register):
//   - BHT[idx(ex_pc)] on cond branch: saturating +1 if taken, -1 if not (00 and 11 saturate).
//   - BTB[idx(ex_pc)] written {valid=1, tag, target, is_jump=ex_jump} on any taken resolve; not-taken leaves
//     BTB unchanged. Conflicting index: newest write replaces.
//  Lookup: hit = valid & tag match; if_pred_taken = hit & (is_jump | ctr[1]); if_pred_target = BTB target.
//   Read and update of same entry in one cycle: lookup returns pre-update state (read-before-write).
//  Counters: br_count +1 per resolved control instr, mispred_count +1 per mispredict; both wrap to 0 at
//   2**CNT_W-1 + 1.
//  Reset mid-operation: rst wins over any update/redirect in that cycle; a pending redirect is dropped.
// STRUCTURE
//  branch_pkg: funct3 localparams (BEQ..BGEU), BHT encodings (SNT=00,WNT=01,WT=10,ST=11), BTB entry struct.
//  One sub-module, bht_btb_array: storage, synchronous reset, async read port (IF), write port (EX).
//  Top holds comparator, target adder, mispredict logic, redirect register, counters.
// TESTING
//  1. Reset, lookup if_pc=0x100 -> if_pred_taken=0; counters 0; redirect_valid=0.
//  2. BEQ rs1=rs2=10, pc=0x1000, imm=0x100, pred NT -> next cycle redirect_valid=1, redirect_pc=0x1100,
//     mispred_count=1; lookup 0x1000 afterwards -> taken, target 0x1100 (ctr 01->10).
//  3. Same BEQ repeated with pred T/0x1100 -> no redirect; ctr saturates at 11 after 2 more; then 3
//     not-taken resolves -> ctr 00, prediction NT, redirect_pc=0x1004 on first of them.
//  4. JALR rs1=0x2000, imm=0xFF -> target 0x20FE; rs1=0xFFFFFFFF, imm=8 -> target 0x6 (wrap, LSB clear).
//  5. BLT vs BLTU rs1=0x7FFFFFFF, rs2=0x80000000 -> BLT not taken, BLTU taken; funct3=010 never taken.
//  6. Lookup+update same index same cycle -> old prediction returned; rst asserted with mispredict ->
//     no redirect next cycle; preload counters to all-ones -> wrap to 0.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// branch_predict_resolve_pkg: funct3 codes, BHT encodings, BTB entry layout and counter update helper
package branch_predict_resolve_pkg;
  localparam int BP_XLEN = 32;
  localparam int BP_TAG_BITS = 8;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_t;
  typedef struct packed {
    logic valid;
    logic is_jump;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_XLEN-1:0] target;
  } btb_entry_t;
  function automatic bht_t bht_next(bht_t c, logic inc);
    return inc ? (c == ST ? ST : bht_t'(c + 2'd1)) : (c == SNT ? SNT : bht_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_predict_resolve_if.sv
// branch_predict_resolve_if: fetch lookup, EX resolve and redirect signals of the branch unit
interface branch_predict_resolve_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] if_pc, if_pred_target, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_target, redirect_pc;
  logic if_pred_taken, ex_valid, ex_branch, ex_jump, ex_alu_src, ex_pred_taken, redirect_valid;
  logic [2:0] ex_funct3;
  modport master(
    output if_pc, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_funct3, ex_branch, ex_jump, ex_alu_src,
           ex_pred_taken, ex_pred_target,
    input if_pred_taken, if_pred_target, redirect_valid, redirect_pc
  );
  modport slave(
    input if_pc, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_funct3, ex_branch, ex_jump, ex_alu_src,
          ex_pred_taken, ex_pred_target,
    output if_pred_taken, if_pred_target, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_predict_resolve_bht_btb_array.sv
// branch_predict_resolve_bht_btb_array: BHT/BTB storage with async read port and synchronous write port
module branch_predict_resolve_bht_btb_array import branch_predict_resolve_pkg::*; #(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output bht_t                rd_ctr,
  output btb_entry_t          rd_entry,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                bht_we,
  input  logic                bht_inc,
  input  logic                btb_we,
  input  btb_entry_t          wr_entry
);
  localparam int N = 2 ** IDX_BITS;
  bht_t bht [N];
  btb_entry_t btb [N];
  assign rd_ctr = bht[rd_idx];
  assign rd_entry = btb[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        bht[i] <= WNT;
        btb[i] <= '0;
      end
    end else begin
      if (bht_we) bht[wr_idx] <= bht_next(bht[wr_idx], bht_inc);
      if (btb_we) btb[wr_idx] <= wr_entry;
    end
  end
endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: EX branch/jump resolution, BHT+BTB prediction, registered redirect and perf counters
module branch_predict_resolve import branch_predict_resolve_pkg::*; #(
  parameter int XLEN = BP_XLEN,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = BP_TAG_BITS,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_resolve_if.slave bus,
  output logic [CNT_W-1:0]       br_count,
  output logic [CNT_W-1:0]       mispred_count
);
  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [XLEN-1:0] sum, target;
  logic ctl, eq, lt, ltu, cond, taken, mispred, unused_pc;
  bht_t rd_ctr;
  btb_entry_t rd_entry, wr_entry;
  assign if_idx = bus.if_pc[IDX_BITS+1:2];
  assign if_tag = bus.if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bus.ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign unused_pc = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:IDX_BITS+TAG_BITS+2]};
  assign ctl = bus.ex_valid & (bus.ex_branch | bus.ex_jump);
  assign sum = (bus.ex_alu_src ? bus.ex_rs1 : bus.ex_pc) + bus.ex_imm;
  assign target = {sum[XLEN-1:1], sum[0] & ~(bus.ex_jump & bus.ex_alu_src)};
  assign eq = bus.ex_rs1 == bus.ex_rs2;
  assign lt = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
  assign ltu = bus.ex_rs1 < bus.ex_rs2;
  assign cond = bus.ex_funct3 == BEQ  ? eq   :
                bus.ex_funct3 == BNE  ? !eq  :
                bus.ex_funct3 == BLT  ? lt   :
                bus.ex_funct3 == BGE  ? !lt  :
                bus.ex_funct3 == BLTU ? ltu  :
                bus.ex_funct3 == BGEU ? !ltu : 1'b0;
  assign taken = bus.ex_jump | (bus.ex_branch & cond);
  assign mispred = ctl & ((taken != bus.ex_pred_taken) | (taken & (bus.ex_pred_target != target)));
  assign wr_entry = '{valid: 1'b1, is_jump: bus.ex_jump, tag: ex_tag, target: target};
  assign bus.if_pred_taken = rd_entry.valid & (rd_entry.tag == if_tag) & (rd_entry.is_jump | rd_ctr[1]);
  assign bus.if_pred_target = rd_entry.target;
  branch_predict_resolve_bht_btb_array #(.IDX_BITS(IDX_BITS)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_idx),
    .rd_ctr   (rd_ctr),
    .rd_entry (rd_entry),
    .wr_idx   (ex_idx),
    .bht_we   (ctl & bus.ex_branch),
    .bht_inc  (taken),
    .btb_we   (ctl & taken),
    .wr_entry (wr_entry)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc <= '0;
      br_count <= '0;
      mispred_count <= '0;
    end else begin
      bus.redirect_valid <= mispred;
      if (mispred) bus.redirect_pc <= taken ? target : bus.ex_pc + XLEN'(4);
      br_count <= br_count + CNT_W'(ctl);
      mispred_count <= mispred_count + CNT_W'(mispred);
    end
  end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: directed and randomized checks of branch_predict_resolve against a behavioural model
module tb_branch_predict_resolve;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  branch_predict_resolve_if #(.XLEN(32)) bus();
  branch_predict_resolve_if #(.XLEN(32)) bus2();
  logic [31:0] br_count, mispred_count;
  logic [2:0] br2, mis2;
  branch_predict_resolve dut (.clk(clk), .rst(rst), .bus(bus), .br_count(br_count), .mispred_count(mispred_count));
  branch_predict_resolve #(.CNT_W(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .br_count(br2), .mispred_count(mis2));
  int total = 0, bad = 0;
  int m_ctr [64];
  bit m_v [64];
  bit m_j [64];
  logic [7:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int unsigned m_br, m_mis;
  bit exp_rv;
  logic [31:0] exp_rpc;
  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction
  function automatic bit m_pred(logic [31:0] pc);
    int i = idx_of(pc);
    return m_v[i] && m_tag[i] == 8'((pc >> 8) & 32'hFF) && (m_j[i] || m_ctr[i] >= 2);
  endfunction
  task automatic set_ex(bit v, logic [31:0] pc, imm, rs1, rs2, logic [2:0] f3, bit br, bit j, bit src, bit pt,
                        logic [31:0] ptg);
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_rs1 = rs1; bus.ex_rs2 = rs2;
    bus.ex_funct3 = f3; bus.ex_branch = br; bus.ex_jump = j; bus.ex_alu_src = src;
    bus.ex_pred_taken = pt; bus.ex_pred_target = ptg;
  endtask
  task automatic idle();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic model_step();
    logic [31:0] tgt;
    bit c, tk, mis;
    int i;
    if (rst) begin
      for (int k = 0; k < 64; k++) begin m_ctr[k] = 1; m_v[k] = 0; m_j[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; end
      m_br = 0; m_mis = 0; exp_rv = 0; exp_rpc = 0;
    end else begin
      exp_rv = 0;
      if (bus.ex_valid && (bus.ex_branch || bus.ex_jump)) begin
        tgt = (bus.ex_alu_src ? bus.ex_rs1 : bus.ex_pc) + bus.ex_imm;
        if (bus.ex_jump && bus.ex_alu_src) tgt[0] = 1'b0;
        case (bus.ex_funct3)
          3'd0: c = bus.ex_rs1 == bus.ex_rs2;
          3'd1: c = bus.ex_rs1 != bus.ex_rs2;
          3'd4: c = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
          3'd5: c = $signed(bus.ex_rs1) >= $signed(bus.ex_rs2);
          3'd6: c = bus.ex_rs1 < bus.ex_rs2;
          3'd7: c = bus.ex_rs1 >= bus.ex_rs2;
          default: c = 0;
        endcase
        tk = bus.ex_jump || (bus.ex_branch && c);
        mis = (tk != bus.ex_pred_taken) || (tk && bus.ex_pred_target != tgt);
        m_br++;
        if (mis) begin m_mis++; exp_rv = 1; exp_rpc = tk ? tgt : bus.ex_pc + 4; end
        i = idx_of(bus.ex_pc);
        if (bus.ex_branch) m_ctr[i] = tk ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
        if (tk) begin m_v[i] = 1; m_j[i] = bus.ex_jump; m_tag[i] = 8'((bus.ex_pc >> 8) & 32'hFF); m_tgt[i] = tgt; end
      end
    end
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; cycle(); cycle(); rst = 0;
    bus.if_pc = 32'h100; #1;
    total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b exp=0", bus.if_pred_taken); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL reset_br got=%0d exp=0", br_count); end
    total++; if (mispred_count !== 32'd0) begin bad++; $display("FAIL reset_mis got=%0d exp=0", mispred_count); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_rpc got=%h exp=0", bus.redirect_pc); end
  endtask
  task automatic test_beq();
    set_ex(1, 32'h1000, 32'h100, 10, 10, 3'd0, 1, 0, 0, 0, 0); cycle();
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL beq_rv got=%b exp=1", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h1100) begin bad++; $display("FAIL beq_rpc got=%h exp=1100", bus.redirect_pc); end
    total++; if (mispred_count !== 32'd1) begin bad++; $display("FAIL beq_mis got=%0d exp=1", mispred_count); end
    total++; if (br_count !== 32'd1) begin bad++; $display("FAIL beq_br got=%0d exp=1", br_count); end
    idle(); bus.if_pc = 32'h1000; #1;
    total++; if (bus.if_pred_taken !== 1'b1) begin bad++; $display("FAIL beq_pred got=%b exp=1", bus.if_pred_taken); end
    total++; if (bus.if_pred_target !== 32'h1100) begin bad++; $display("FAIL beq_ptgt got=%h exp=1100", bus.if_pred_target); end
    cycle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL beq_pulse got=%b exp=0", bus.redirect_valid); end
  endtask
  task automatic test_saturate();
    repeat (2) begin
      set_ex(1, 32'h1000, 32'h100, 10, 10, 3'd0, 1, 0, 0, 1, 32'h1100); cycle();
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL sat_rv got=%b exp=0", bus.redirect_valid); end
    end
    for (int k = 0; k < 3; k++) begin
      set_ex(1, 32'h1000, 32'h100, 10, 11, 3'd0, 1, 0, 0, m_pred(32'h1000), 32'h1100); cycle();
      total++; if (bus.redirect_valid !== exp_rv) begin bad++; $display("FAIL nt_rv got=%b exp=%b", bus.redirect_valid, exp_rv); end
      if (k == 0) begin
        total++; if (bus.redirect_pc !== 32'h1004) begin bad++; $display("FAIL nt_rpc got=%h exp=1004", bus.redirect_pc); end
      end
    end
    idle(); bus.if_pc = 32'h1000; #1;
    total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL nt_pred got=%b exp=0", bus.if_pred_taken); end
    cycle();
  endtask
  task automatic test_jump();
    set_ex(1, 32'h3000, 32'hFF, 32'h2000, 0, 3'd0, 0, 1, 1, 0, 0); cycle();
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL jalr_rv got=%b exp=1", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h20FE) begin bad++; $display("FAIL jalr_rpc got=%h exp=20fe", bus.redirect_pc); end
    set_ex(1, 32'h3000, 32'h8, 32'hFFFFFFFF, 0, 3'd0, 0, 1, 1, 1, 32'h20FE); cycle();
    total++; if (bus.redirect_pc !== 32'h6) begin bad++; $display("FAIL jalr_wrap got=%h exp=6", bus.redirect_pc); end
    set_ex(1, 32'h4000, 32'h40, 0, 0, 3'd0, 0, 1, 0, 1, 32'h4040); cycle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL jal_rv got=%b exp=0", bus.redirect_valid); end
    idle(); bus.if_pc = 32'h4000; #1;
    total++; if (bus.if_pred_taken !== 1'b1) begin bad++; $display("FAIL jal_pred got=%b exp=1", bus.if_pred_taken); end
    total++; if (bus.if_pred_target !== 32'h4040) begin bad++; $display("FAIL jal_ptgt got=%h exp=4040", bus.if_pred_target); end
    cycle();
  endtask
  task automatic test_compare();
    int unsigned br_before;
    set_ex(1, 32'h5000, 32'h20, 32'h7FFFFFFF, 32'h80000000, 3'd4, 1, 0, 0, 0, 0); cycle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL blt_rv got=%b exp=0", bus.redirect_valid); end
    set_ex(1, 32'h5000, 32'h20, 32'h7FFFFFFF, 32'h80000000, 3'd6, 1, 0, 0, 0, 0); cycle();
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL bltu_rv got=%b exp=1", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h5020) begin bad++; $display("FAIL bltu_rpc got=%h exp=5020", bus.redirect_pc); end
    set_ex(1, 32'h5000, 32'h20, 5, 5, 3'd2, 1, 0, 0, 1, 32'h5020); cycle();
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL f010_rv got=%b exp=1", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h5004) begin bad++; $display("FAIL f010_rpc got=%h exp=5004", bus.redirect_pc); end
    br_before = m_br;
    set_ex(0, 32'h5000, 32'h20, 1, 2, 3'd6, 1, 0, 0, 0, 0); cycle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL nv_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (br_count !== br_before) begin bad++; $display("FAIL nv_br got=%0d exp=%0d", br_count, br_before); end
    set_ex(1, 32'h5000, 32'h20, 1, 1, 3'd0, 0, 0, 0, 1, 32'h5020); cycle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL nonctl_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (br_count !== br_before) begin bad++; $display("FAIL nonctl_br got=%0d exp=%0d", br_count, br_before); end
    idle();
  endtask
  task automatic test_same_cycle();
    set_ex(1, 32'h6010, 32'h40, 3, 3, 3'd0, 1, 0, 0, 0, 0); bus.if_pc = 32'h6010; #1;
    total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL rbw_old got=%b exp=0", bus.if_pred_taken); end
    cycle(); idle(); #1;
    total++; if (bus.if_pred_taken !== 1'b1) begin bad++; $display("FAIL rbw_new got=%b exp=1", bus.if_pred_taken); end
    total++; if (bus.if_pred_target !== 32'h6050) begin bad++; $display("FAIL rbw_tgt got=%h exp=6050", bus.if_pred_target); end
    cycle();
  endtask
  task automatic test_reset_mid();
    set_ex(1, 32'h7000, 32'h10, 0, 0, 3'd0, 0, 1, 0, 0, 0); rst = 1; cycle(); rst = 0; idle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", br_count, mispred_count); end
    bus.if_pc = 32'h6010; #1;
    total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL rstmid_pred got=%b exp=0", bus.if_pred_taken); end
    cycle();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rv2 got=%b exp=0", bus.redirect_valid); end
  endtask
  task automatic test_wrap();
    bus2.ex_valid = 1; bus2.ex_jump = 1; bus2.ex_pc = 32'h100; bus2.ex_imm = 32'h4; bus2.ex_pred_taken = 0;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      total++; if (br2 !== 3'(k % 8)) begin bad++; $display("FAIL wrap_br k=%0d got=%0d exp=%0d", k, br2, k % 8); end
      total++; if (mis2 !== 3'(k % 8)) begin bad++; $display("FAIL wrap_mis k=%0d got=%0d exp=%0d", k, mis2, k % 8); end
    end
    bus2.ex_valid = 0;
  endtask
  task automatic test_random();
    logic [31:0] pc, ptg;
    int kind, i;
    bit pt;
    for (int n = 0; n < 600; n++) begin
      pc = $urandom & 32'h0000_0FFC;
      kind = $urandom_range(0, 4);
      i = idx_of(pc);
      pt = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pred(pc);
      ptg = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFC) : m_tgt[i];
      set_ex(kind != 0, pc, ($urandom_range(0, 15) << 2), ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 3)),
             ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 3)), 3'($urandom), kind == 2 || kind == 3,
             kind == 4, 1'($urandom), pt, ptg);
      bus.if_pc = $urandom & 32'h0000_0FFC; #1;
      total++; if (bus.if_pred_taken !== m_pred(bus.if_pc)) begin bad++; $display("FAIL rnd_pred n=%0d got=%b exp=%b", n, bus.if_pred_taken, m_pred(bus.if_pc)); end
      if (m_pred(bus.if_pc)) begin
        total++; if (bus.if_pred_target !== m_tgt[idx_of(bus.if_pc)]) begin bad++; $display("FAIL rnd_ptgt n=%0d got=%h exp=%h", n, bus.if_pred_target, m_tgt[idx_of(bus.if_pc)]); end
      end
      cycle();
      total++; if (bus.redirect_valid !== exp_rv) begin bad++; $display("FAIL rnd_rv n=%0d got=%b exp=%b", n, bus.redirect_valid, exp_rv); end
      if (exp_rv) begin
        total++; if (bus.redirect_pc !== exp_rpc) begin bad++; $display("FAIL rnd_rpc n=%0d got=%h exp=%h", n, bus.redirect_pc, exp_rpc); end
      end
      total++; if (br_count !== m_br || mispred_count !== m_mis) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, br_count, mispred_count, m_br, m_mis); end
    end
    idle();
  endtask
  initial begin
    idle(); bus.if_pc = 0;
    bus2.if_pc = 0; bus2.ex_valid = 0; bus2.ex_pc = 0; bus2.ex_imm = 0; bus2.ex_rs1 = 0; bus2.ex_rs2 = 0;
    bus2.ex_funct3 = 0; bus2.ex_branch = 0; bus2.ex_jump = 0; bus2.ex_alu_src = 0; bus2.ex_pred_taken = 0;
    bus2.ex_pred_target = 0;
    test_reset();
    test_beq();
    test_saturate();
    test_jump();
    test_compare();
    test_same_cycle();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
